nvram_uploader: RTL and testbench
=================================

Name: nvram_uploader

Overview:
- Reads the Williams CMOS high-score RAM (4-bit nibbles) and streams it to the HPS as bytes, so scores can be saved to SD.
- Acts as the upload-side counterpart of the ROM download path.
- Sits between hps_io's upload handshake and a read port on the CMOS RAM inside the game core.
- Halts the game CPU for the whole session so the dump is coherent.

Parameters:
- ADDR_W, 10, CMOS RAM address width (nibble addresses).
- PACK, 1. When 1, each output byte is {nibble at 2A+1, nibble at 2A}. When 0, each byte is mem_q at address A.
- BYTES, 512, number of valid upload bytes. Addresses at or above BYTES read as 8'hFF.
- MEM_LAT, 1, cycles from mem_rd to valid mem_q (1..3).
- UP_INDEX, 4, ioctl_index value that selects this block.

Ports:
- clk_sys  in  1  system clock (12 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  level, high for the upload session.
- ioctl_index  in  16  upload target select.
- ioctl_rd  in  1  one-cycle request for the byte at ioctl_addr.
- ioctl_addr  in  25  byte address of the request.
- ioctl_din  out  8  returned byte.
- din_valid  out  1  high while ioctl_din holds the answer to the most recent accepted request.
- halt_req  out  1  request that the game CPU stop.
- halt_ack  in  1  CPU is halted.
- mem_addr  out  ADDR_W  CMOS read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_q  in  8  read data; only [3:0] is used when PACK=1.
- busy  out  1  a fetch is in progress.
- overrun  out  1  sticky: a request was dropped.

Behaviour:
- Reset values (async, reset_n low): ioctl_din=0, din_valid=0, halt_req=0, mem_addr=0, mem_rd=0, busy=0, overrun=0, pending slot empty, state IDLE.
- sel = ioctl_upload && ioctl_index==UP_INDEX.

State machine:
- IDLE: on sel, go to HALT_WAIT and set halt_req=1. Clear overrun on entry to HALT_WAIT.
- HALT_WAIT: wait for halt_ack=1, then go to READY. An ioctl_rd received here is latched into the pending slot.
- READY: on ioctl_rd, or with the pending slot full, capture address A and go to FETCH.
  - Set din_valid=0 and busy=1 at that clock edge.
  - If A >= BYTES: ioctl_din=8'hFF, din_valid=1 on the next cycle, back to READY with no memory access.
- FETCH_LO: mem_addr = PACK ? 2A : A; mem_rd pulses for 1 cycle. Wait MEM_LAT cycles, then capture:
  - PACK=1: nibble into ioctl_din[3:0].
  - PACK=0: full mem_q into ioctl_din.
  - If PACK=0, go to DONE; otherwise go to FETCH_HI.
- FETCH_HI: mem_addr = 2A+1; mem_rd pulses; after MEM_LAT cycles capture mem_q[3:0] into ioctl_din[7:4], go to DONE.
- DONE: din_valid=1, busy=0, return to READY.
- Any state: if sel falls, go to IDLE on the next edge.
  - halt_req=0, din_valid=0, busy=0.
  - In-flight fetch is aborted; late mem_q is ignored; pending slot cleared.

Latency and holding:
- Latency from ioctl_rd to din_valid in range:
  - PACK=1: 2*(MEM_LAT+1)+1 cycles.
  - PACK=0: MEM_LAT+2 cycles.
- Latency for an out-of-range address: 2 cycles.
- ioctl_din holds its value until the next accepted request.

Requests and memory timing:
- Pending slot is one deep. A request arriving while busy=1 is latched and served right after DONE (back-to-back, no idle cycle).
- A request arriving while the slot is already full is dropped and sets overrun=1 (sticky until the next session start).
- ioctl_rd in IDLE is ignored.
- mem_rd never asserts while halt_ack=0.
- halt_ack dropping mid-fetch: the current fetch completes, then the block waits in HALT_WAIT before serving the pending request.
- Address arithmetic: A is truncated to ADDR_W-PACK bits only after the BYTES range check, so there is no wrap-around aliasing.

Test Plan:
- Preload CMOS nibbles 0x3 at addr 0 and 0xA at addr 1; PACK=1, MEM_LAT=1; upload index 4, halt_ack 2 cycles after halt_req, ioctl_rd addr 0 -> mem_rd at addr 0 then addr 1, ioctl_din=8'hA3, din_valid exactly 5 cycles after ioctl_rd.
- Sequential reads addr 0..511 with rd spaced 8 cycles -> 512 bytes match the packed RAM image; halt_req high throughout; overrun=0.
- ioctl_rd addr 512 -> ioctl_din=8'hFF after 2 cycles, no mem_rd pulse.
- Three ioctl_rd pulses on consecutive cycles -> first two served in order, third dropped, overrun=1; next session start clears overrun.
- ioctl_rd asserted before halt_ack -> no mem_rd until halt_ack=1, then request served from the pending slot.
- Drop ioctl_upload mid FETCH_HI -> next cycle halt_req=0, din_valid=0, busy=0; a new session returns correct data for addr 0. Assert reset_n low mid-fetch -> all outputs at reset values immediately.

Source files
------------

// File: rtl/nvram_uploader.sv
// -----------------------------------------------------------------------------
// nvram_uploader
//   Streams the Williams CMOS high-score RAM (4-bit nibbles) to the HPS as bytes
//   through hps_io's upload handshake, so scores can be saved to SD. The game
//   CPU is held halted for the whole upload session to keep the dump coherent.
//
// Parameters
//   ADDR_W   CMOS RAM address width (nibble addresses)
//   PACK     1: byte = {nib[2A+1], nib[2A]}; 0: byte = mem_q[A]
//   BYTES    number of valid upload bytes; addresses >= BYTES read as 8'hFF
//   MEM_LAT  cycles from mem_rd to valid mem_q (1..3)
//   UP_INDEX ioctl_index value selecting this block
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   ioctl_upload in   high for the whole upload session
//   ioctl_index  in   upload target select
//   ioctl_rd     in   one-cycle request for the byte at ioctl_addr
//   ioctl_addr   in   byte address of the request
//   ioctl_din    out  returned byte (held until the next accepted request)
//   din_valid    out  ioctl_din answers the most recent accepted request
//   halt_req     out  request that the game CPU stop
//   halt_ack     in   game CPU is halted
//   mem_addr     out  CMOS read address
//   mem_rd       out  one-cycle read strobe
//   mem_q        in   read data ([3:0] only when PACK=1)
//   busy         out  a fetch is in progress
//   overrun      out  sticky: a request was dropped (cleared at session start)
// -----------------------------------------------------------------------------
module nvram_uploader #(
  parameter int ADDR_W   = 10,
  parameter int PACK     = 1,
  parameter int BYTES    = 512,
  parameter int MEM_LAT  = 1,
  parameter int UP_INDEX = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              din_valid,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              overrun
);

  // Width of the captured byte address once it is known to be in range.
  localparam int          AW       = ADDR_W - PACK;
  localparam logic [24:0] BYTES_W  = 25'(BYTES);
  localparam logic [1:0]  LAT_INIT = 2'(MEM_LAT);
  localparam logic [15:0] INDEX_W  = 16'(UP_INDEX);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_READY     = 3'd2,
    ST_OOR       = 3'd3,
    ST_FETCH_LO  = 3'd4,
    ST_FETCH_HI  = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Nibble address for byte address a; hi selects the odd nibble when packing.
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [AW-1:0] a, input logic hi);
    logic [ADDR_W-1:0] r;
    r = (ADDR_W'(a) << PACK) | ADDR_W'(hi);
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [1:0]        lat_q, lat_d;
  logic              hi_issued_q, hi_issued_d;
  logic              pend_vld_q, pend_vld_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic [7:0]        din_q, din_d;
  logic              din_valid_q, din_valid_d;
  logic              halt_req_q, halt_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              sel_s;
  logic [24:0]       req_addr_s;
  logic              rd_take_s;

  assign sel_s = ioctl_upload && (ioctl_index == INDEX_W);

  // Next-state and output logic of the upload session FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    hi_issued_d = hi_issued_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    din_d       = din_q;
    din_valid_d = din_valid_q;
    halt_req_d  = halt_req_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    // A queued request always takes priority over a fresh one.
    req_addr_s  = pend_vld_q ? pend_addr_q : ioctl_addr;
    rd_take_s   = 1'b0;

    if (!sel_s) begin
      // Session ended (or never started): abort everything, release the CPU.
      state_d     = ST_IDLE;
      halt_req_d  = 1'b0;
      din_valid_d = 1'b0;
      busy_d      = 1'b0;
      pend_vld_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_HALT_WAIT;
          halt_req_d = 1'b1;
          overrun_d  = 1'b0;
          pend_vld_d = 1'b0;
        end
        ST_HALT_WAIT: begin
          if (halt_ack) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_HALT_WAIT;
          end
        end
        ST_READY: begin
          if (!halt_ack) begin
            state_d = ST_HALT_WAIT;
          end else if (pend_vld_q || ioctl_rd) begin
            rd_take_s   = !pend_vld_q;
            pend_vld_d  = 1'b0;
            busy_d      = 1'b1;
            din_valid_d = 1'b0;
            // Range check on the full address before truncation: no aliasing.
            if (req_addr_s >= BYTES_W) begin
              state_d = ST_OOR;
            end else begin
              addr_d      = req_addr_s[AW-1:0];
              mem_addr_d  = mk_addr(req_addr_s[AW-1:0], 1'b0);
              mem_rd_d    = 1'b1;
              lat_d       = LAT_INIT;
              hi_issued_d = 1'b1;
              state_d     = ST_FETCH_LO;
            end
          end else begin
            state_d = ST_READY;
          end
        end
        ST_OOR: begin
          din_d   = 8'hFF;
          state_d = ST_DONE;
        end
        ST_FETCH_LO: begin
          if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
          end else if (PACK != 0) begin
            din_d[3:0] = mem_q[3:0];
            state_d    = ST_FETCH_HI;
            // Issue the odd-nibble read straight away unless the CPU left halt.
            if (halt_ack) begin
              mem_addr_d  = mk_addr(addr_q, 1'b1);
              mem_rd_d    = 1'b1;
              lat_d       = LAT_INIT;
              hi_issued_d = 1'b1;
            end else begin
              hi_issued_d = 1'b0;
            end
          end else begin
            din_d   = mem_q;
            state_d = ST_DONE;
          end
        end
        ST_FETCH_HI: begin
          if (!hi_issued_q) begin
            // Deferred read: mem_rd only goes out while the CPU is halted.
            if (halt_ack) begin
              mem_addr_d  = mk_addr(addr_q, 1'b1);
              mem_rd_d    = 1'b1;
              lat_d       = LAT_INIT;
              hi_issued_d = 1'b1;
            end else begin
              hi_issued_d = 1'b0;
            end
          end else if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
          end else begin
            din_d[7:4] = mem_q[3:0];
            state_d    = ST_DONE;
          end
        end
        ST_DONE: begin
          din_valid_d = 1'b1;
          busy_d      = 1'b0;
          if (halt_ack) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_HALT_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Requests not consumed directly go to the one-deep slot, else are dropped.
      if (ioctl_rd && !rd_take_s && (state_q != ST_IDLE)) begin
        if (!pend_vld_d) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = ioctl_addr;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        pend_addr_d = pend_addr_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lat_q       <= 2'd0;
      hi_issued_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 25'd0;
      din_q       <= 8'd0;
      din_valid_q <= 1'b0;
      halt_req_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      hi_issued_q <= hi_issued_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      halt_req_q  <= halt_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ioctl_din = din_q;
  assign din_valid = din_valid_q;
  assign halt_req  = halt_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_nvram_uploader.sv
// -----------------------------------------------------------------------------
// tb_nvram_uploader
//   Directed bench for nvram_uploader (PACK=1, MEM_LAT=1, BYTES=512, index 4).
//   A nibble RAM model answers mem_rd one cycle later; expected bytes come from
//   hand-computed table entries and from the RAM image for the full sweep.
// -----------------------------------------------------------------------------
module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        din_valid;
  logic        halt_req;
  logic        halt_ack;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ram [0:1023];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          lat;
    int          pulses;
  } vec_t;

  vec_t vecs [10];

  nvram_uploader #(
    .ADDR_W(10), .PACK(1), .BYTES(512), .MEM_LAT(1), .UP_INDEX(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .din_valid(din_valid), .halt_req(halt_req),
    .halt_ack(halt_ack), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // CMOS RAM model: one cycle read latency, upper nibble is junk.
  always @(posedge clk_sys) begin
    if (mem_rd) mem_q <= {4'hC, ram[mem_addr]};
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request; measures latency to din_valid and the mem_rd pulses issued.
  task automatic run_req(input logic [24:0] a, input logic [7:0] exp_din,
                         input int exp_lat, input int exp_pulses);
    int         pulses;
    int         lat;
    logic [9:0] pa0, pa1, ea;
    pulses = 0; lat = 0; pa0 = 10'd0; pa1 = 10'd0;
    ea = 10'(a << 1);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 0; k <= 20; k++) begin
      if (mem_rd) begin
        if (pulses == 0) pa0 = mem_addr;
        else if (pulses == 1) pa1 = mem_addr;
        pulses++;
      end
      if (din_valid && lat == 0) lat = k;
      if (lat != 0) break;
      tick();
    end
    chk("req_latency", 32'(lat), 32'(exp_lat));
    chk("req_din", 32'(ioctl_din), 32'(exp_din));
    chk("req_mem_rd_pulses", 32'(pulses), 32'(exp_pulses));
    chk("req_busy_done", 32'(busy), 32'd0);
    if (exp_pulses == 2) begin
      chk("req_addr_lo", 32'(pa0), 32'(ea));
      chk("req_addr_hi", 32'(pa1), 32'(ea + 10'd1));
    end
  endtask

  logic [7:0] v0, v1;
  int         l0, l1, nval, lat;
  logic       prev, seen;

  initial begin
    // Nibble image: n[3:0]^n[7:4]^n[9:8], with the two test-plan nibbles at 0/1.
    for (int n = 0; n < 1024; n++) begin
      logic [9:0] nn;
      nn = 10'(n);
      ram[n] = nn[3:0] ^ nn[7:4] ^ {2'b00, nn[9:8]};
    end
    ram[0] = 4'h3;
    ram[1] = 4'hA;

    vecs[0] = '{25'd0,        8'hA3, 5, 2};
    vecs[1] = '{25'd1,        8'h32, 5, 2};
    vecs[2] = '{25'd100,      8'h54, 5, 2};
    vecs[3] = '{25'd200,      8'h98, 5, 2};
    vecs[4] = '{25'd257,      8'h10, 5, 2};
    vecs[5] = '{25'd300,      8'hEF, 5, 2};
    vecs[6] = '{25'd511,      8'h32, 5, 2};
    vecs[7] = '{25'd512,      8'hFF, 2, 0};
    vecs[8] = '{25'd1025,     8'hFF, 2, 0};
    vecs[9] = '{25'h1FFFFFF,  8'hFF, 2, 0};

    reset_n = 1'b1; ioctl_upload = 1'b0; ioctl_index = 16'd4;
    ioctl_rd = 1'b0; ioctl_addr = 25'd0; halt_ack = 1'b0;
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("rst_din", 32'(ioctl_din), 32'd0);
    chk("rst_din_valid", 32'(din_valid), 32'd0);
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // Session start; CPU acknowledges two cycles after halt_req.
    ioctl_upload = 1'b1;
    tick();
    chk("start_halt_req", 32'(halt_req), 32'd1);
    tick(); tick();
    halt_ack = 1'b1;
    tick(); tick();

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].addr, vecs[i].din, vecs[i].lat, vecs[i].pulses);
      tick(); tick();
    end
    chk("vec_overrun", 32'(overrun), 32'd0);

    // Full sweep, one request every 8 cycles.
    for (int a = 0; a < 512; a++) begin
      ioctl_addr = 25'(a);
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      repeat (7) tick();
      chk("sweep_byte", {22'd0, din_valid, halt_req, ioctl_din},
          {22'd0, 1'b1, 1'b1, ram[2*a+1], ram[2*a]});
    end
    chk("sweep_overrun", 32'(overrun), 32'd0);

    // Three back-to-back requests: two served in order, the third dropped.
    ioctl_addr = 25'd1;   ioctl_rd = 1'b1; tick();
    ioctl_addr = 25'd100; tick();
    ioctl_addr = 25'd200; tick();
    ioctl_rd = 1'b0;
    prev = din_valid; nval = 0; l0 = 0; l1 = 0; v0 = 8'd0; v1 = 8'd0;
    for (int k = 3; k <= 30; k++) begin
      tick();
      if (din_valid && !prev) begin
        if (nval == 0) begin v0 = ioctl_din; l0 = k; end
        else if (nval == 1) begin v1 = ioctl_din; l1 = k; end
        nval++;
      end
      prev = din_valid;
    end
    chk("b2b_count", 32'(nval), 32'd2);
    chk("b2b_first", {v0, 24'(l0)}, {8'h32, 24'd5});
    chk("b2b_second", {v1, 24'(l1)}, {8'h54, 24'd11});
    chk("b2b_overrun", 32'(overrun), 32'd1);

    // End session: CPU released, overrun sticky until the next session.
    ioctl_upload = 1'b0;
    halt_ack = 1'b0;
    tick();
    chk("end_halt_req", 32'(halt_req), 32'd0);
    chk("end_overrun_sticky", 32'(overrun), 32'd1);

    // ioctl_rd with no session is ignored.
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mem_rd || busy || din_valid) seen = 1'b1;
      tick();
    end
    chk("idle_rd_ignored", 32'(seen), 32'd0);

    // New session clears overrun; request before halt_ack waits in the slot.
    ioctl_upload = 1'b1;
    tick();
    chk("restart_overrun_clear", 32'(overrun), 32'd0);
    chk("restart_halt_req", 32'(halt_req), 32'd1);
    ioctl_addr = 25'd300; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_rd) seen = 1'b1;
    end
    chk("prehalt_no_mem_rd", 32'(seen), 32'd0);
    halt_ack = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (din_valid) begin lat = k; break; end
    end
    chk("prehalt_latency", 32'(lat), 32'd7);
    chk("prehalt_din", 32'(ioctl_din), 32'h0000_00EF);
    tick();

    // Drop the session while the odd-nibble read is in flight.
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick(); tick();
    chk("abort_in_fetch_hi", {22'd0, mem_rd, mem_addr}, {22'd0, 1'b1, 10'd1});
    ioctl_upload = 1'b0;
    tick();
    chk("abort_outputs", {29'd0, halt_req, din_valid, busy}, 32'd0);
    repeat (4) tick();
    chk("abort_late_data_ignored", {30'd0, din_valid, busy}, 32'd0);
    ioctl_upload = 1'b1;
    repeat (3) tick();
    run_req(25'd0, 8'hA3, 5, 2);

    // Asynchronous reset in the middle of a fetch.
    ioctl_addr = 25'd1; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {9'd0, ioctl_din, din_valid, halt_req, mem_addr, mem_rd, busy, overrun}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
